// File: rtl/rv32_boot_sequencer.sv
// rv32_boot_sequencer
//   Holds the RV32 core in reset, streams program/data words from the host
//   link into the instruction and data RAMs through their debug write ports,
//   then releases the core after a fixed reset-hold period.
//
// Ports
//   CPU_CLK, CPU_RST_N       core clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_op selects LOAD_I (00),
//                            LOAD_D (01), RUN (10), HALT (11)
//   cmd_base, cmd_len        first word index and word count of a load
//   wr_valid/wr_ready        load-word handshake, wr_data is the word
//   core_rst                 active-high reset to the core
//   inst_a2/wd2/we2          instruction RAM debug write port (byte address)
//   data_a2/wd2/we2          data RAM debug write port (byte address)
//   busy                     high while loading or releasing the core
//   done                     one-cycle pulse: load complete / core started
//   err                      one-cycle pulse: command rejected
module rv32_boot_sequencer #(
    parameter int unsigned INST_WORDS = 4096,
    parameter int unsigned DATA_WORDS = 4096,
    parameter int unsigned RST_HOLD   = 4
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_base,
    input  logic [15:0] cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        core_rst,
    output logic [31:0] inst_a2,
    output logic [31:0] inst_wd2,
    output logic [3:0]  inst_we2,
    output logic [31:0] data_a2,
    output logic [31:0] data_wd2,
    output logic [3:0]  data_we2,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_HALT,
        S_LOAD,
        S_RELEASE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD_I = 2'b00,
        OP_LOAD_D = 2'b01,
        OP_RUN    = 2'b10,
        OP_HALT   = 2'b11
    } op_t;

    state_t      state;
    logic        loadData;
    logic [15:0] loadBase;
    logic [15:0] loadLen;
    logic [15:0] wordIdx;
    logic [7:0]  holdCnt;

    logic        cmdFire;
    logic [31:0] loadEnd;
    logic        loadFits;
    logic [31:0] wordAddr;

    always_comb begin
        cmdFire  = cmd_valid & cmd_ready;
        // Zero-extended sum, so a base near 64K cannot wrap into range.
        loadEnd  = 32'(cmd_base) + 32'(cmd_len);
        loadFits = loadEnd <= ((op_t'(cmd_op) == OP_LOAD_D) ? DATA_WORDS : INST_WORDS);
        wordAddr = (32'(loadBase) + 32'(wordIdx)) << 2;
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state     <= S_HALT;
            core_rst  <= 1'b1;
            cmd_ready <= 1'b1;
            wr_ready  <= 1'b0;
            inst_a2   <= '0;
            inst_wd2  <= '0;
            inst_we2  <= '0;
            data_a2   <= '0;
            data_wd2  <= '0;
            data_we2  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            loadData  <= 1'b0;
            loadBase  <= '0;
            loadLen   <= '0;
            wordIdx   <= '0;
            holdCnt   <= '0;
        end else begin
            // Strobes default low so each assertion lasts exactly one cycle.
            inst_we2 <= '0;
            data_we2 <= '0;
            done     <= 1'b0;
            err      <= 1'b0;

            case (state)
                S_HALT: begin
                    if (cmdFire) begin
                        case (op_t'(cmd_op))
                            OP_LOAD_I, OP_LOAD_D: begin
                                if (!loadFits) begin
                                    err <= 1'b1;
                                end else if (cmd_len == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    loadData  <= (op_t'(cmd_op) == OP_LOAD_D);
                                    loadBase  <= cmd_base;
                                    loadLen   <= cmd_len;
                                    wordIdx   <= '0;
                                    state     <= S_LOAD;
                                    cmd_ready <= 1'b0;
                                    wr_ready  <= 1'b1;
                                    busy      <= 1'b1;
                                end
                            end
                            OP_RUN: begin
                                holdCnt   <= 8'(RST_HOLD);
                                state     <= S_RELEASE;
                                cmd_ready <= 1'b0;
                                busy      <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                S_LOAD: begin
                    // wr_ready is held high for the whole LOAD state.
                    if (wr_valid) begin
                        if (loadData) begin
                            data_a2  <= wordAddr;
                            data_wd2 <= wr_data;
                            data_we2 <= 4'hF;
                        end else begin
                            inst_a2  <= wordAddr;
                            inst_wd2 <= wr_data;
                            inst_we2 <= 4'hF;
                        end
                        wordIdx <= wordIdx + 16'd1;
                        if (wordIdx == loadLen - 16'd1) begin
                            state     <= S_HALT;
                            wr_ready  <= 1'b0;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end

                S_RELEASE: begin
                    // Loaded with RST_HOLD on entry; leaving on 1 gives
                    // exactly RST_HOLD cycles in this state.
                    if (holdCnt == 8'd1) begin
                        state     <= S_RUN;
                        core_rst  <= 1'b0;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                    holdCnt <= holdCnt - 8'd1;
                end

                S_RUN: begin
                    if (cmdFire) begin
                        if (op_t'(cmd_op) == OP_HALT) begin
                            core_rst <= 1'b1;
                            state    <= S_HALT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_boot_sequencer.sv
`timescale 1ns/1ps
module tb_rv32_boot_sequencer;

    localparam int unsigned IW   = 4096;
    localparam int unsigned DW   = 4096;
    localparam int unsigned HOLD = 4;

    localparam logic [1:0] OP_LI = 2'b00;
    localparam logic [1:0] OP_LD = 2'b01;
    localparam logic [1:0] OP_RN = 2'b10;
    localparam logic [1:0] OP_HL = 2'b11;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_base = '0;
    logic [15:0] cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        core_rst;
    logic [31:0] inst_a2, inst_wd2, data_a2, data_wd2;
    logic [3:0]  inst_we2, data_we2;
    logic        busy, done, err;

    rv32_boot_sequencer #(
        .INST_WORDS(IW),
        .DATA_WORDS(DW),
        .RST_HOLD  (HOLD)
    ) dut (
        .CPU_CLK  (CPU_CLK),
        .CPU_RST_N(CPU_RST_N),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_base (cmd_base),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .core_rst (core_rst),
        .inst_a2  (inst_a2),
        .inst_wd2 (inst_wd2),
        .inst_we2 (inst_we2),
        .data_a2  (data_a2),
        .data_wd2 (data_wd2),
        .data_we2 (data_we2),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    int unsigned cyc = 0;
    always @(posedge CPU_CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected observable event: kind 0 = instruction write, 1 = data write,
    // 2 = no write (done/err/core_rst change only).
    typedef struct {
        int unsigned cyc;
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic        err;
        logic        crst;
    } ev_t;

    ev_t expQ[$];
    bit  running = 0;

    logic [31:0] noWords[$];
    logic [31:0] prog[$];

    function automatic void push(int unsigned c, int k, logic [31:0] a, logic [31:0] d,
                                 logic dn, logic er, logic cr);
        ev_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.data = d;
        e.done = dn; e.err = er; e.crst = cr;
        expQ.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a write, a strobe
    // or a core_rst change.
    logic prevRst = 1'b1;
    always @(negedge CPU_CLK) begin
        ev_t e;
        logic [3:0] eIwe, eDwe;
        bit ok;
        if (!CPU_RST_N) begin
            prevRst = core_rst;
        end else begin
            while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missing_event expected at cycle %0d kind %0d done %b err %b rst %b, got no event",
                         expQ[0].cyc, expQ[0].kind, expQ[0].done, expQ[0].err, expQ[0].crst);
                void'(expQ.pop_front());
            end
            if (inst_we2 != 4'h0 || data_we2 != 4'h0 || done || err || core_rst != prevRst) begin
                checks++;
                if (expQ.size() == 0 || expQ[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_event cycle %0d iwe %h ia %h dwe %h da %h done %b err %b rst %b, expected none",
                             cyc, inst_we2, inst_a2, data_we2, data_a2, done, err, core_rst);
                end else begin
                    e = expQ.pop_front();
                    eIwe = (e.kind == 0) ? 4'hF : 4'h0;
                    eDwe = (e.kind == 1) ? 4'hF : 4'h0;
                    ok = (inst_we2 == eIwe) && (data_we2 == eDwe) && (done == e.done) &&
                         (err == e.err) && (core_rst == e.crst);
                    if (e.kind == 0) ok = ok && (inst_a2 == e.addr) && (inst_wd2 == e.data);
                    if (e.kind == 1) ok = ok && (data_a2 == e.addr) && (data_wd2 == e.data);
                    if (!ok) begin
                        errors++;
                        $display("FAIL event cycle %0d got iwe %h ia %h iwd %h dwe %h da %h dwd %h done %b err %b rst %b expected kind %0d a %h wd %h done %b err %b rst %b",
                                 cyc, inst_we2, inst_a2, inst_wd2, data_we2, data_a2, data_wd2, done, err, core_rst,
                                 e.kind, e.addr, e.data, e.done, e.err, e.crst);
                    end
                end
            end
            prevRst = core_rst;
        end
    end

    task automatic checkIdle(input string name);
        check({name, "_core_rst"}, 32'(core_rst), 32'd1);
        check({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({name, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check({name, "_we2"}, {24'd0, inst_we2, data_we2}, 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Issues one command at a negedge and predicts its outcome from the
    // sequencer's rules; returns at a negedge once the command has played out.
    task automatic issue(input logic [1:0] op, input logic [15:0] base, input logic [15:0] len,
                         input logic [31:0] words[$], input int gapMin, input int gapMax,
                         input int abortAfter);
        int unsigned waits;
        int unsigned depth;
        bit          legal;
        bit          doWords;
        bit          doHold;
        int unsigned g;
        waits   = 0;
        depth   = (op == OP_LD) ? DW : IW;
        legal   = (32'(base) + 32'(len)) <= depth;
        doWords = 0;
        doHold  = 0;
        cmd_op = op; cmd_base = base; cmd_len = len; cmd_valid = 1'b1;
        while (!cmd_ready) begin
            if (waits == 40) begin
                checks++; errors++;
                $display("FAIL cmd_handshake_timeout cmd_ready stayed %b expected 1", cmd_ready);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "command handshake timeout");
            end
            @(negedge CPU_CLK);
            waits++;
        end
        if (running) begin
            if (op == OP_HL) begin
                push(cyc + 1, 2, '0, '0, 1'b0, 1'b0, 1'b1);
                running = 0;
            end else begin
                push(cyc + 1, 2, '0, '0, 1'b0, 1'b1, 1'b0);
            end
        end else begin
            case (op)
                OP_LI, OP_LD: begin
                    if (!legal)        push(cyc + 1, 2, '0, '0, 1'b0, 1'b1, 1'b1);
                    else if (len == 0) push(cyc + 1, 2, '0, '0, 1'b1, 1'b0, 1'b1);
                    else               doWords = 1;
                end
                OP_RN: begin
                    push(cyc + 1 + HOLD, 2, '0, '0, 1'b1, 1'b0, 1'b0);
                    running = 1;
                    doHold  = 1;
                end
                default: ;
            endcase
        end
        @(negedge CPU_CLK);
        cmd_valid = 1'b0;

        if (doHold) begin
            for (int unsigned i = 0; i < HOLD; i++) begin
                check("release_busy", 32'(busy), 32'd1);
                check("release_core_rst", 32'(core_rst), 32'd1);
                check("release_cmd_ready", 32'(cmd_ready), 32'd0);
                @(negedge CPU_CLK);
            end
            check("run_core_rst", 32'(core_rst), 32'd0);
            check("run_busy", 32'(busy), 32'd0);
        end

        if (doWords) begin
            for (int unsigned k = 0; k < 32'(len); k++) begin
                if (abortAfter >= 0 && k == 32'(abortAfter)) begin
                    wr_valid = 1'b0;
                    @(negedge CPU_CLK);
                    return;
                end
                g = (k > 0) ? $urandom_range(gapMax, gapMin) : 0;
                if (g > 0) begin
                    wr_valid = 1'b0;
                    repeat (g) @(negedge CPU_CLK);
                end
                wr_valid = 1'b1;
                wr_data  = (k < words.size()) ? words[k] : $urandom;
                check("load_wr_ready", 32'(wr_ready), 32'd1);
                check("load_busy", 32'(busy), 32'd1);
                push(cyc + 1, (op == OP_LD) ? 1 : 0, (32'(base) + k) * 4, wr_data,
                     (k == 32'(len) - 1), 1'b0, 1'b1);
                @(negedge CPU_CLK);
            end
            wr_valid = 1'b0;
            check("load_end_wr_ready", 32'(wr_ready), 32'd0);
            check("load_end_cmd_ready", 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        #2000000;
        checks++; errors++;
        $display("FAIL global_timeout simulation did not finish, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [15:0] b, l;
        int unsigned r;
        int unsigned dep;
        prog = '{32'h00000013, 32'h00100093, 32'h00208113};

        #1 CPU_RST_N = 1'b0;
        @(negedge CPU_CLK);
        checkIdle("in_reset");
        repeat (2) @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;
        @(negedge CPU_CLK);
        checkIdle("after_reset");
        check("reset_addr", inst_a2 | data_a2 | inst_wd2 | data_wd2, 32'd0);
        repeat (3) @(negedge CPU_CLK);
        checkIdle("idle_no_cmd");

        // Program load, back-to-back words.
        issue(OP_LI, 16'd0, 16'd3, prog, 0, 0, -1);
        // Overflow by one word, then the last legal span and an empty load.
        issue(OP_LD, 16'd4094, 16'd3, noWords, 0, 0, -1);
        issue(OP_LD, 16'd4093, 16'd3, noWords, 0, 0, -1);
        issue(OP_LD, 16'd10, 16'd0, noWords, 0, 0, -1);
        // Gapped data load.
        issue(OP_LD, 16'd8, 16'd2, noWords, 3, 3, -1);

        // Stray load words outside LOAD must be ignored.
        wr_valid = 1'b1;
        wr_data  = 32'hDEADBEEF;
        repeat (4) begin
            @(negedge CPU_CLK);
            check("stray_wr_ready", 32'(wr_ready), 32'd0);
        end
        wr_valid = 1'b0;

        issue(OP_HL, 16'd0, 16'd0, noWords, 0, 0, -1);
        issue(OP_RN, 16'd0, 16'd0, noWords, 0, 0, -1);
        issue(OP_LI, 16'd0, 16'd1, noWords, 0, 0, -1);
        issue(OP_RN, 16'd0, 16'd0, noWords, 0, 0, -1);
        issue(OP_HL, 16'd0, 16'd0, noWords, 0, 0, -1);
        check("halted_core_rst", 32'(core_rst), 32'd1);

        // Reset in the middle of a five-word load.
        issue(OP_LI, 16'd100, 16'd5, noWords, 0, 0, 2);
        @(negedge CPU_CLK);
        CPU_RST_N = 1'b0;
        #1;
        checkIdle("mid_load_reset");
        running = 0;
        repeat (2) @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;
        @(negedge CPU_CLK);
        issue(OP_LI, 16'd200, 16'd4, noWords, 0, 1, -1);

        // Randomized command stream.
        for (int unsigned n = 0; n < 60; n++) begin
            op  = 2'($urandom_range(3, 0));
            r   = $urandom_range(3, 0);
            dep = (op == OP_LD) ? DW : IW;
            case (r)
                0: begin b = 16'($urandom_range(4095, 0)); l = '0; end
                1: begin b = 16'(dep - $urandom_range(6, 0)); l = 16'($urandom_range(6, 1)); end
                2: begin b = 16'($urandom_range(4000, 0)); l = 16'($urandom_range(5, 1)); end
                default: begin b = 16'($urandom); l = 16'($urandom_range(65535, 5000)); end
            endcase
            issue(op, b, l, noWords, 0, 2, -1);
            repeat ($urandom_range(2, 0)) @(negedge CPU_CLK);
        end

        repeat (HOLD + 4) @(negedge CPU_CLK);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending events expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_boot_sequencer.md
Name: rv32_boot_sequencer

Overview:
- Owns the lifetime of the RV32 pipeline core: holds it in reset, streams program and data words from a host link into the instruction and data RAMs, then releases the core to run.
- Drives the core reset input and the second (debug) write port of both RAMs.
- Sits between the board-level host/UART word stream and the core top level.
- Replaces hand-driven debug-port pokes with a handshaked, checked load sequence.

Parameters:
- INST_WORDS, 4096, instruction RAM depth in 32-bit words.
- DATA_WORDS, 4096, data RAM depth in 32-bit words.
- RST_HOLD, 4, cycles the core reset stays asserted after a RUN command is accepted (legal range 1..255).

Ports:
- CPU_CLK  in  1  core clock; all state changes on its rising edge.
- CPU_RST_N  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 LOAD_I, 01 LOAD_D, 10 RUN, 11 HALT.
- cmd_base  in  16  first word index of a load.
- cmd_len  in  16  number of words in a load.
- wr_valid  in  1  load word offered.
- wr_ready  out  1  word accepted when wr_valid & wr_ready.
- wr_data  in  32  load word.
- core_rst  out  1  active-high reset to the core.
- inst_a2  out  32  instruction RAM debug byte address.
- inst_wd2  out  32  instruction RAM debug write data.
- inst_we2  out  4  instruction RAM debug byte write enables.
- data_a2  out  32  data RAM debug byte address.
- data_wd2  out  32  data RAM debug write data.
- data_we2  out  4  data RAM debug byte write enables.
- busy  out  1  high in LOAD and RELEASE.
- done  out  1  one-cycle pulse when a load completes or the core starts running.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (CPU_RST_N=0, asynchronous): state=HALT, core_rst=1, cmd_ready=1, wr_ready=0, all a2/wd2=0, all we2=0, busy=0, done=0, err=0, internal counters=0.
- Reset asserted mid-load abandons the load; words already written remain in RAM.
- All outputs are registered.

State HALT:
- core_rst=1, cmd_ready=1.
- LOAD_I/LOAD_D:
  - Legal when cmd_base+cmd_len <= depth of the target RAM (17-bit compare, no wrap-around). Latch op, base and len; go to LOAD.
  - Illegal (overflow): err pulse next cycle, stay in HALT, no RAM write.
- LOAD with cmd_len=0: no write, done pulse next cycle, stay in HALT.
- RUN: load hold counter with RST_HOLD; go to RELEASE.
- HALT: no effect; no err, no done.

State LOAD:
- cmd_ready=0, wr_ready=1, busy=1.
- Each accepted word at index k writes in the following cycle:
  - selected a2 = (base+k)*4
  - selected wd2 = wr_data
  - selected we2 = 4'hF for exactly that one cycle
  - the other RAM's we2 = 0
- One word per cycle is sustainable; wr_valid gaps insert idle cycles with we2=0.
- After the word with k=len-1 is accepted: wr_ready=0 next cycle, done pulses in the same cycle as the final we2, return to HALT.
- wr_valid asserted outside LOAD is ignored.

State RELEASE:
- core_rst=1, busy=1, cmd_ready=0.
- Counter decrements each cycle. After exactly RST_HOLD cycles in RELEASE: core_rst=0, done pulse, enter RUN.

State RUN:
- core_rst=0, cmd_ready=1.
- HALT: core_rst=1 on the next cycle, go to HALT.
- LOAD_I/LOAD_D/RUN: err pulse, command consumed and ignored, core keeps running.

Other rules:
- Address arithmetic is zero-extended to 32 bits; the upper bits of a2 are 0.
- done and err are never high in the same cycle.

Test Plan:
- Release CPU_RST_N; no commands → core_rst=1, cmd_ready=1, inst_we2=data_we2=0, busy=0.
- LOAD_I base=0 len=3, words 0x00000013, 0x00100093, 0x00208113 back-to-back → inst_we2=F for 3 consecutive cycles at inst_a2=0x0, 0x4, 0x8 with matching wd2; done pulses with the third write; state HALT.
- LOAD_D base=4094 len=3 with DATA_WORDS=4096 → err pulse, no data_we2. LOAD_D len=0 → done pulse only.
- LOAD_D base=8 len=2 with a 3-cycle wr_valid gap between words → data_a2=0x20 then 0x24; data_we2=F only in the cycle after each acceptance.
- RUN with RST_HOLD=4 → core_rst stays 1 for 4 cycles, then 0; done pulses; then LOAD_I → err pulse, core_rst stays 0; HALT → core_rst=1 next cycle.
- Assert CPU_RST_N=0 after 2 of 5 words in LOAD_I → immediate HALT outputs with core_rst=1, we2=0; a subsequent legal LOAD_I completes normally.
